tif_frame_scheduler: RTL

Scheduler and frame sequencer for the serial test interface controller, which produces tclk/trst/dq_en/sr_en from a 0..39 frame counter.
- Owns the free-running frame counter (count40) that drives that controller.
- Round-robin arbitrates NREQ requesters; the winner owns one 40-cycle frame.
- Presents the winner's command word for serialisation.
- Collects the serial read bits and returns them to the owner as a tagged response.

---
 rtl/tif_pkg.sv | 21 ++
 rtl/tif_rr_arbiter.sv | 52 +++++
 rtl/tif_frame_scheduler.sv | 120 ++++++++++++
 3 files changed

// File: rtl/tif_pkg.sv
// Shared constants, state type and helpers for the test-interface frame scheduler.
package tif_pkg;

  localparam int FRAME_LEN    = 40;
  localparam int GNT_CYCLE    = 38;
  localparam int LOAD_CYCLE   = 39;
  localparam int RD_START_DEF = 16;
  localparam int NOP_CMD_DEF  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_HOLD  = 2'd2
  } sched_st_e;

  // Width of a requester index; never zero, even for a single requester.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tif_rr_arbiter.sv
// Round-robin arbiter: combinational pick starting at the pointer,
// pointer moves past the winner whenever an enabled grant is issued.
module tif_rr_arbiter
  import tif_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_en,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt,
  output logic            o_any,
  output logic [IDW-1:0]  o_id
);

  logic [IDW-1:0] r_ptr;
  logic           w_any;
  logic [IDW-1:0] w_id;

  // First active request at or after the pointer, wrapping around.
  always_comb begin : pick
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_any && i_req[idx]) begin
        w_any = 1'b1;
        w_id  = IDW'(idx);
      end
    end
  end

  // One-hot grant only while enabled.
  always_comb begin
    o_gnt = '0;
    if (i_en && w_any) o_gnt[w_id] = 1'b1;
  end

  assign o_any = w_any;
  assign o_id  = w_id;

  // Pointer advances to the index after the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_ptr <= '0;
    else if (i_en && w_any) r_ptr <= (w_id == IDW'(NREQ - 1)) ? '0 : w_id + IDW'(1);
  end

endmodule

// File: rtl/tif_frame_scheduler.sv
// Frame scheduler for the serial test interface: free-running 0..39 frame
// counter, round-robin frame ownership, command presentation and read-back
// collection. Optional macro TIF_RSP_PARITY_EN adds an odd-parity check on
// the captured read word.
module tif_frame_scheduler
  import tif_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int CMD_W    = 7,
  parameter int RD_W     = 10,
  parameter int RD_START = RD_START_DEF,
  parameter int NOP_CMD  = NOP_CMD_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*CMD_W-1:0]   i_cmd_in,
  output logic [NREQ-1:0]         o_gnt,
  output logic [5:0]              o_count40,
  output logic [CMD_W-1:0]        o_cmd_out,
  output logic                    o_cmd_load,
  input  logic                    i_sr_en,
  input  logic                    i_rd_bit,
  output logic                    o_rsp_valid,
  output logic [2:0]              o_rsp_id,
  output logic [RD_W-1:0]         o_rsp_data,
  output logic                    o_rsp_err
);

  localparam int IDW = id_w(NREQ);
  localparam int BCW = $clog2(RD_W + 2);

  logic [5:0]       r_cnt;
  logic [CMD_W-1:0] r_cmd;
  logic             r_load;
  logic             r_pend_own;
  logic [IDW-1:0]   r_pend_id;
  logic [IDW-1:0]   r_owner_id;
  sched_st_e        r_st;
  logic [RD_W-1:0]  r_cap;
  logic [BCW-1:0]   r_bcnt;

  logic             w_arb_en;
  logic             w_any;
  logic [IDW-1:0]   w_id;
  logic             w_err;

  assign w_arb_en = (r_cnt == 6'(GNT_CYCLE));

  tif_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_arb_en),
    .i_req (i_req),
    .o_gnt (o_gnt),
    .o_any (w_any),
    .o_id  (w_id)
  );

  // Free-running frame counter, wraps 39 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= (r_cnt == 6'(LOAD_CYCLE)) ? '0 : r_cnt + 6'd1;
  end

  // Frame sequencer: grant/load at 38, response cycle at 39, ownership hand-over at 39->0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st       <= ST_IDLE;
      r_cmd      <= CMD_W'(NOP_CMD);
      r_load     <= 1'b0;
      r_pend_own <= 1'b0;
      r_pend_id  <= '0;
      r_owner_id <= '0;
    end else if (r_cnt == 6'(GNT_CYCLE)) begin
      // The winner's command is presented from 39 onward so the shifter can load it.
      r_load     <= 1'b1;
      r_cmd      <= w_any ? i_cmd_in[int'(w_id)*CMD_W +: CMD_W] : CMD_W'(NOP_CMD);
      r_pend_own <= w_any;
      r_pend_id  <= w_id;
      if (r_st == ST_OWNED) r_st <= ST_HOLD;
    end else if (r_cnt == 6'(LOAD_CYCLE)) begin
      r_load     <= 1'b0;
      r_st       <= r_pend_own ? ST_OWNED : ST_IDLE;
      r_owner_id <= r_pend_id;
    end else begin
      r_load     <= 1'b0;
    end
  end

  // Read-data capture: MSB-first shift, saturating bit count, cleared at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap  <= '0;
      r_bcnt <= '0;
    end else if (r_cnt == 6'(LOAD_CYCLE)) begin
      r_cap  <= '0;
      r_bcnt <= '0;
    end else if (i_sr_en && (r_cnt >= 6'(RD_START))) begin
      r_cap  <= {r_cap[RD_W-2:0], i_rd_bit};
      if (r_bcnt != BCW'(RD_W + 1)) r_bcnt <= r_bcnt + BCW'(1);
    end
  end

`ifdef TIF_RSP_PARITY_EN
  // Last bit is odd parity: the whole word must hold an odd number of ones.
  assign w_err = (r_bcnt != BCW'(RD_W)) | ~(^r_cap);
`else
  assign w_err = (r_bcnt != BCW'(RD_W));
`endif

  assign o_count40   = r_cnt;
  assign o_cmd_out   = r_cmd;
  assign o_cmd_load  = r_load;
  assign o_rsp_valid = (r_st == ST_HOLD);
  assign o_rsp_id    = o_rsp_valid ? 3'(r_owner_id) : 3'd0;
  assign o_rsp_data  = o_rsp_valid ? r_cap : '0;
  assign o_rsp_err   = o_rsp_valid & w_err;

endmodule
